// File: rtl/stat_pkg.sv
// Shared types and helpers for the multi-channel statistics accumulator.
package stat_pkg;

  // Snapshot sequencer: wait for a request, then copy one lane to the outputs.
  typedef enum logic [0:0] {
    SNAP_IDLE    = 1'b0,
    SNAP_CAPTURE = 1'b1
  } snap_state_t;

  // Saturating adds are done on a wide carrier word and clamped to the real
  // width. Callers must keep their operand widths below SAT_MAX_W.
  localparam int SAT_MAX_W = 128;
  typedef logic [SAT_MAX_W-1:0] sat_word_t;

  localparam sat_word_t SAT_ONE = {{(SAT_MAX_W-1){1'b0}}, 1'b1};

  // Empty-lane values; lanes slice off the width they need.
  localparam sat_word_t EMPTY_ACC = {SAT_MAX_W{1'b0}};
  localparam sat_word_t EMPTY_CNT = {SAT_MAX_W{1'b0}};
  localparam sat_word_t EMPTY_MIN = {SAT_MAX_W{1'b1}};
  localparam sat_word_t EMPTY_MAX = {SAT_MAX_W{1'b0}};
  localparam logic      EMPTY_OVF = 1'b0;

  // a + b clamped to w bits of all-ones. Bit SAT_MAX_W of the result is the
  // clamp flag; bits [w-1:0] carry the (possibly clamped) sum. Both operands
  // must already fit in w bits.
  function automatic logic [SAT_MAX_W:0] sat_add(input sat_word_t a,
                                                 input sat_word_t b,
                                                 input int        w);
    logic [SAT_MAX_W:0] lim;
    logic [SAT_MAX_W:0] full;
    lim  = ({{SAT_MAX_W{1'b0}}, 1'b1} << w) - {{SAT_MAX_W{1'b0}}, 1'b1};
    full = {1'b0, a} + {1'b0, b};
    if (full > lim) begin
      sat_add = {1'b1, lim[SAT_MAX_W-1:0]};
    end else begin
      sat_add = {1'b0, full[SAT_MAX_W-1:0]};
    end
  endfunction

endpackage

// File: rtl/stat_lane.sv
// One channel's statistics registers: sum, sum of squares, count, min, max
// and a sticky saturation flag. Clear beats load-with-sample beats update.
module stat_lane
  import stat_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 64,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                upd,
  input  logic [DATA_W-1:0]   data,
  input  logic [2*DATA_W-1:0] square,
  input  logic                clr,
  input  logic                clr_load,
  output logic [ACC_W-1:0]    sum,
  output logic [ACC_W-1:0]    sumsq,
  output logic [CNT_W-1:0]    count,
  output logic [DATA_W-1:0]   min,
  output logic [DATA_W-1:0]   max,
  output logic                ovf
);

  logic [ACC_W-1:0]  sum_q, sum_d;
  logic [ACC_W-1:0]  sumsq_q, sumsq_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic              ovf_q, ovf_d;

  logic [SAT_MAX_W:0] sum_inc_s;
  logic [SAT_MAX_W:0] sumsq_inc_s;
  logic [SAT_MAX_W:0] cnt_inc_s;
  logic               unused_hi_s;

  assign sum_inc_s   = sat_add(sat_word_t'(sum_q),   sat_word_t'(data),   ACC_W);
  assign sumsq_inc_s = sat_add(sat_word_t'(sumsq_q), sat_word_t'(square), ACC_W);
  assign cnt_inc_s   = sat_add(sat_word_t'(count_q), SAT_ONE,             CNT_W);

  // Upper carrier bits are always zero after clamping; fold them away.
  assign unused_hi_s = ^{sum_inc_s[SAT_MAX_W-1:ACC_W],
                         sumsq_inc_s[SAT_MAX_W-1:ACC_W],
                         cnt_inc_s[SAT_MAX_W-1:CNT_W]};

  // Next lane state: empty, restart from one sample, accumulate, or hold.
  always_comb begin
    sum_d   = sum_q;
    sumsq_d = sumsq_q;
    count_d = count_q;
    min_d   = min_q;
    max_d   = max_q;
    ovf_d   = ovf_q;
    if (clr) begin
      sum_d   = EMPTY_ACC[ACC_W-1:0];
      sumsq_d = EMPTY_ACC[ACC_W-1:0];
      count_d = EMPTY_CNT[CNT_W-1:0];
      min_d   = EMPTY_MIN[DATA_W-1:0];
      max_d   = EMPTY_MAX[DATA_W-1:0];
      ovf_d   = EMPTY_OVF;
    end else if (clr_load) begin
      // A single sample can never reach all-ones, so no clamp is possible.
      sum_d   = ACC_W'(data);
      sumsq_d = ACC_W'(square);
      count_d = SAT_ONE[CNT_W-1:0];
      min_d   = data;
      max_d   = data;
      ovf_d   = EMPTY_OVF;
    end else if (upd) begin
      sum_d   = sum_inc_s[ACC_W-1:0];
      sumsq_d = sumsq_inc_s[ACC_W-1:0];
      count_d = cnt_inc_s[CNT_W-1:0];
      min_d   = (data < min_q) ? data : min_q;
      max_d   = (data > max_q) ? data : max_q;
      ovf_d   = ovf_q | sum_inc_s[SAT_MAX_W] | sumsq_inc_s[SAT_MAX_W]
                      | cnt_inc_s[SAT_MAX_W];
    end else begin
      ovf_d   = ovf_q;
    end
  end

  // Lane registers, empty out of reset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sum_q   <= EMPTY_ACC[ACC_W-1:0];
      sumsq_q <= EMPTY_ACC[ACC_W-1:0];
      count_q <= EMPTY_CNT[CNT_W-1:0];
      min_q   <= EMPTY_MIN[DATA_W-1:0];
      max_q   <= EMPTY_MAX[DATA_W-1:0];
      ovf_q   <= EMPTY_OVF;
    end else begin
      sum_q   <= sum_d;
      sumsq_q <= sumsq_d;
      count_q <= count_d;
      min_q   <= min_d;
      max_q   <= max_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum   = sum_q;
  assign sumsq = sumsq_q;
  assign count = count_q;
  assign min   = min_q;
  assign max   = max_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/stat_accum.sv
// Multi-channel streaming statistics accumulator: a registered input stage,
// CH lanes, and a two-state snapshot sequencer with optional clear-on-read.
module stat_accum
  import stat_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int CH     = 4,
  parameter  int ACC_W  = 64,
  parameter  int CNT_W  = 32,
  localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              en,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clear,
  input  logic              snap_req,
  input  logic [CH_W-1:0]   snap_ch,
  input  logic              snap_clr,
  output logic              snap_busy,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_sum,
  output logic [ACC_W-1:0]  out_sumsq,
  output logic [CNT_W-1:0]  out_count,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic              out_ovf
);

  localparam logic [CH_W:0] CH_LIM = (CH_W+1)'(CH);

  // ---- stage 1 ----
  logic                s1_valid_q, s1_valid_d;
  logic [CH_W-1:0]     s1_ch_q, s1_ch_d;
  logic [DATA_W-1:0]   s1_data_q, s1_data_d;
  logic [2*DATA_W-1:0] s1_sq_q, s1_sq_d;
  logic                in_hit_s;

  assign in_hit_s = ({1'b0, in_ch} < CH_LIM);

  // Accept a sample when enabled and addressed to an existing channel.
  always_comb begin
    s1_valid_d = in_valid & en & in_hit_s;
    if (s1_valid_d) begin
      s1_ch_d   = in_ch;
      s1_data_d = in_data;
      s1_sq_d   = (2*DATA_W)'(in_data) * (2*DATA_W)'(in_data);
    end else begin
      s1_ch_d   = s1_ch_q;
      s1_data_d = s1_data_q;
      s1_sq_d   = s1_sq_q;
    end
  end

  // Stage-1 registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s1_valid_q <= 1'b0;
      s1_ch_q    <= {CH_W{1'b0}};
      s1_data_q  <= {DATA_W{1'b0}};
      s1_sq_q    <= {(2*DATA_W){1'b0}};
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_ch_q    <= s1_ch_d;
      s1_data_q  <= s1_data_d;
      s1_sq_q    <= s1_sq_d;
    end
  end

  // ---- snapshot sequencer ----
  snap_state_t     state_q, state_d;
  logic [CH_W-1:0] snap_ch_q, snap_ch_d;
  logic            snap_clr_q, snap_clr_d;
  logic            capture_s;
  logic            snap_hit_s;

  assign capture_s  = (state_q == SNAP_CAPTURE);
  assign snap_hit_s = ({1'b0, snap_ch_q} < CH_LIM);

  // Latch a request in IDLE; CAPTURE always lasts exactly one cycle.
  always_comb begin
    state_d    = state_q;
    snap_ch_d  = snap_ch_q;
    snap_clr_d = snap_clr_q;
    case (state_q)
      SNAP_IDLE: begin
        if (snap_req) begin
          state_d    = SNAP_CAPTURE;
          snap_ch_d  = snap_ch;
          snap_clr_d = snap_clr;
        end else begin
          state_d    = SNAP_IDLE;
        end
      end
      SNAP_CAPTURE: state_d = SNAP_IDLE;
      default:      state_d = SNAP_IDLE;
    endcase
  end

  // Sequencer registers; reset aborts any outstanding snapshot.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= SNAP_IDLE;
      snap_ch_q  <= {CH_W{1'b0}};
      snap_clr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_ch_q  <= snap_ch_d;
      snap_clr_q <= snap_clr_d;
    end
  end

  assign snap_busy = capture_s;

  // ---- lanes ----
  logic [ACC_W-1:0]  lane_sum_s   [CH];
  logic [ACC_W-1:0]  lane_sumsq_s [CH];
  logic [CNT_W-1:0]  lane_count_s [CH];
  logic [DATA_W-1:0] lane_min_s   [CH];
  logic [DATA_W-1:0] lane_max_s   [CH];
  logic [CH-1:0]     lane_ovf_s;
  logic [CH-1:0]     upd_s, cor_s, clr_s, load_s;

  for (genvar gi = 0; gi < CH; gi++) begin : g_lane
    // A clear-on-read that meets a sample for the same lane restarts the
    // lane from that sample, so it is neither lost nor counted twice.
    assign upd_s[gi]  = s1_valid_q && (s1_ch_q == CH_W'(gi));
    assign cor_s[gi]  = capture_s && snap_clr_q && snap_hit_s && (snap_ch_q == CH_W'(gi));
    assign clr_s[gi]  = clear || (cor_s[gi] && !upd_s[gi]);
    assign load_s[gi] = cor_s[gi] && upd_s[gi];

    stat_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .CNT_W  (CNT_W)
    ) u_lane (
      .clk      (clk),
      .nreset   (nreset),
      .upd      (upd_s[gi]),
      .data     (s1_data_q),
      .square   (s1_sq_q),
      .clr      (clr_s[gi]),
      .clr_load (load_s[gi]),
      .sum      (lane_sum_s[gi]),
      .sumsq    (lane_sumsq_s[gi]),
      .count    (lane_count_s[gi]),
      .min      (lane_min_s[gi]),
      .max      (lane_max_s[gi]),
      .ovf      (lane_ovf_s[gi])
    );
  end

  // ---- output mux and registers ----
  logic [ACC_W-1:0]  sel_sum_s, sel_sumsq_s;
  logic [CNT_W-1:0]  sel_count_s;
  logic [DATA_W-1:0] sel_min_s, sel_max_s;
  logic              sel_ovf_s;

  // Pick the requested lane; a nonexistent channel reads as empty with ovf set.
  always_comb begin
    sel_sum_s   = EMPTY_ACC[ACC_W-1:0];
    sel_sumsq_s = EMPTY_ACC[ACC_W-1:0];
    sel_count_s = EMPTY_CNT[CNT_W-1:0];
    sel_min_s   = EMPTY_MIN[DATA_W-1:0];
    sel_max_s   = EMPTY_MAX[DATA_W-1:0];
    sel_ovf_s   = 1'b1;
    if (snap_hit_s) begin
      sel_sum_s   = lane_sum_s[snap_ch_q];
      sel_sumsq_s = lane_sumsq_s[snap_ch_q];
      sel_count_s = lane_count_s[snap_ch_q];
      sel_min_s   = lane_min_s[snap_ch_q];
      sel_max_s   = lane_max_s[snap_ch_q];
      sel_ovf_s   = lane_ovf_s[snap_ch_q];
    end else begin
      sel_ovf_s   = 1'b1;
    end
  end

  logic              out_valid_q, out_valid_d;
  logic [ACC_W-1:0]  out_sum_q, out_sum_d, out_sumsq_q, out_sumsq_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;
  logic [DATA_W-1:0] out_min_q, out_min_d, out_max_q, out_max_d;
  logic              out_ovf_q, out_ovf_d;

  // Load the outputs from pre-edge lane values in CAPTURE, hold otherwise.
  always_comb begin
    out_valid_d = capture_s;
    if (capture_s) begin
      out_sum_d   = sel_sum_s;
      out_sumsq_d = sel_sumsq_s;
      out_count_d = sel_count_s;
      out_min_d   = sel_min_s;
      out_max_d   = sel_max_s;
      out_ovf_d   = sel_ovf_s;
    end else begin
      out_sum_d   = out_sum_q;
      out_sumsq_d = out_sumsq_q;
      out_count_d = out_count_q;
      out_min_d   = out_min_q;
      out_max_d   = out_max_q;
      out_ovf_d   = out_ovf_q;
    end
  end

  // Output registers; out_min resets to all-ones, everything else to zero.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= {ACC_W{1'b0}};
      out_sumsq_q <= {ACC_W{1'b0}};
      out_count_q <= {CNT_W{1'b0}};
      out_min_q   <= {DATA_W{1'b1}};
      out_max_q   <= {DATA_W{1'b0}};
      out_ovf_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_sumsq_q <= out_sumsq_d;
      out_count_q <= out_count_d;
      out_min_q   <= out_min_d;
      out_max_q   <= out_max_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_sumsq = out_sumsq_q;
  assign out_count = out_count_q;
  assign out_min   = out_min_q;
  assign out_max   = out_max_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_stat_accum.sv
// Bench for stat_accum: a behavioural model per channel, expected snapshots
// queued when the request is driven and checked when out_valid appears.
module tb_stat_accum;

  localparam int DATA_W = 16;
  localparam int CH     = 3;
  localparam int ACC_W  = 32;
  localparam int CNT_W  = 4;
  localparam int CH_W   = 2;

  localparam longint ACC_MAX = 64'h0000_0000_FFFF_FFFF;
  localparam int     CNT_MAX = 15;

  logic              clk = 1'b0;
  logic              nreset = 1'b0;
  logic              en = 1'b0;
  logic              in_valid = 1'b0;
  logic [CH_W-1:0]   in_ch = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              clear = 1'b0;
  logic              snap_req = 1'b0;
  logic [CH_W-1:0]   snap_ch = '0;
  logic              snap_clr = 1'b0;
  logic              snap_busy;
  logic              out_valid;
  logic [ACC_W-1:0]  out_sum, out_sumsq;
  logic [CNT_W-1:0]  out_count;
  logic [DATA_W-1:0] out_min, out_max;
  logic              out_ovf;

  stat_accum #(.DATA_W(DATA_W), .CH(CH), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .nreset(nreset), .en(en), .in_valid(in_valid), .in_ch(in_ch),
    .in_data(in_data), .clear(clear), .snap_req(snap_req), .snap_ch(snap_ch),
    .snap_clr(snap_clr), .snap_busy(snap_busy), .out_valid(out_valid),
    .out_sum(out_sum), .out_sumsq(out_sumsq), .out_count(out_count),
    .out_min(out_min), .out_max(out_max), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]  sumsq;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mn;
    logic [DATA_W-1:0] mx;
    logic              ovf;
    int                due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model state per channel.
  longint m_sum[CH], m_sumsq[CH];
  int     m_cnt[CH], m_min[CH], m_max[CH];
  bit     m_ovf[CH];
  bit     m_busy = 1'b0;

  task automatic m_empty(input int c);
    m_sum[c] = 0; m_sumsq[c] = 0; m_cnt[c] = 0;
    m_min[c] = 'hFFFF; m_max[c] = 0; m_ovf[c] = 1'b0;
  endtask

  task automatic m_apply(input int c, input int d);
    m_sum[c]   = m_sum[c] + d;
    m_sumsq[c] = m_sumsq[c] + longint'(d) * longint'(d);
    m_cnt[c]   = m_cnt[c] + 1;
    if (m_sum[c] > ACC_MAX)   begin m_sum[c] = ACC_MAX;   m_ovf[c] = 1'b1; end
    if (m_sumsq[c] > ACC_MAX) begin m_sumsq[c] = ACC_MAX; m_ovf[c] = 1'b1; end
    if (m_cnt[c] > CNT_MAX)   begin m_cnt[c] = CNT_MAX;   m_ovf[c] = 1'b1; end
    if (d < m_min[c]) m_min[c] = d;
    if (d > m_max[c]) m_max[c] = d;
  endtask

  // One clock of stimulus; the model is advanced in the order the hardware
  // resolves a single edge (clear, snapshot capture point, clear-on-read, sample).
  task automatic drive(input bit v, input int ch, input int d, input bit e,
                       input bit sr, input int sc, input bit scl, input bit clr);
    exp_t x;
    bit   busy_n;
    if (clr) for (int c = 0; c < CH; c++) m_empty(c);
    busy_n = 1'b0;
    if (sr && !m_busy) begin
      busy_n = 1'b1;
      if (sc < CH) begin
        x.sum = m_sum[sc][ACC_W-1:0]; x.sumsq = m_sumsq[sc][ACC_W-1:0];
        x.cnt = CNT_W'(m_cnt[sc]); x.mn = DATA_W'(m_min[sc]);
        x.mx = DATA_W'(m_max[sc]); x.ovf = m_ovf[sc];
        if (scl) m_empty(sc);
      end else begin
        x.sum = '0; x.sumsq = '0; x.cnt = '0; x.mn = '1; x.mx = '0; x.ovf = 1'b1;
      end
      x.due = cyc + 2;
      exp_q.push_back(x);
    end
    if (v && e && ch < CH) m_apply(ch, d);
    in_valid = v; in_ch = CH_W'(ch); in_data = DATA_W'(d); en = e;
    snap_req = sr; snap_ch = CH_W'(sc); snap_clr = scl; clear = clr;
    @(posedge clk);
    #1;
    m_busy = busy_n;
    in_valid = 1'b0; snap_req = 1'b0; clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic samp(input int ch, input int d);
    drive(1, ch, d, 1, 0, 0, 0, 0);
  endtask

  task automatic snap(input int ch, input bit clr_on_read);
    drive(0, 0, 0, 1, 1, ch, clr_on_read, 0);
  endtask

  // Scoreboard: every out_valid pops one expectation, including its cycle.
  always @(negedge clk) begin
    if (nreset && out_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL snap_unexpected: out_valid at cycle %0d with nothing expected", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (cyc !== mon_e.due || out_sum !== mon_e.sum || out_sumsq !== mon_e.sumsq ||
            out_count !== mon_e.cnt || out_min !== mon_e.mn || out_max !== mon_e.mx ||
            out_ovf !== mon_e.ovf) begin
          n_bad++;
          $display("FAIL snap_result: got cyc=%0d sum=%h sumsq=%h cnt=%0d min=%h max=%h ovf=%b, expected cyc=%0d sum=%h sumsq=%h cnt=%0d min=%h max=%h ovf=%b",
                   cyc, out_sum, out_sumsq, out_count, out_min, out_max, out_ovf,
                   mon_e.due, mon_e.sum, mon_e.sumsq, mon_e.cnt, mon_e.mn, mon_e.mx, mon_e.ovf);
        end
      end
    end
  end

  task automatic test_reset;
    for (int c = 0; c < CH; c++) m_empty(c);
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || snap_busy !== 1'b0 || out_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got valid=%b busy=%b ovf=%b, expected 0 0 0", out_valid, snap_busy, out_ovf);
    end
    n_cmp++;
    if (out_sum !== '0 || out_sumsq !== '0 || out_count !== '0) begin
      n_bad++;
      $display("FAIL reset_acc: got sum=%h sumsq=%h cnt=%0d, expected 0 0 0", out_sum, out_sumsq, out_count);
    end
    n_cmp++;
    if (out_min !== 16'hFFFF || out_max !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_minmax: got min=%h max=%h, expected ffff 0000", out_min, out_max);
    end
    nreset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    samp(2, 3); samp(2, 5); samp(2, 7);
    snap(2, 0);
    n_cmp++;
    if (snap_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_busy: got %b, expected 1", snap_busy);
    end
    idle(3);
    n_cmp++;
    if (snap_busy !== 1'b0 || out_sum !== 32'd15 || out_count !== 4'd3) begin
      n_bad++;
      $display("FAIL basic_hold: got busy=%b sum=%0d cnt=%0d, expected 0 15 3", snap_busy, out_sum, out_count);
    end
    snap(0, 0); idle(1);
    snap(1, 0); idle(2);
  endtask

  task automatic test_interleave_en;
    for (int i = 0; i < 12; i++) drive(1, i % 2, 10 + i, !(i == 5 || i == 6), 0, 0, 0, 0);
    drive(1, 3, 99, 1, 0, 0, 0, 0);
    snap(0, 1); idle(1);
    snap(1, 1); idle(2);
  endtask

  task automatic test_saturation;
    samp(0, 'hFFFF); samp(0, 'hFFFF); samp(0, 'hFFFF);
    snap(0, 0); idle(1);
    samp(0, 'hFFFF); samp(0, 1);
    snap(0, 1); idle(2);
    snap(0, 0); idle(2);
    for (int i = 0; i < 17; i++) samp(2, 1);
    snap(2, 1); idle(2);
  endtask

  task automatic test_cor_coincident;
    samp(1, 4); samp(1, 6);
    drive(1, 1, 9, 1, 1, 1, 1, 0);
    idle(2);
    snap(1, 0); idle(2);
  endtask

  task automatic test_clear_capture;
    samp(2, 10); samp(0, 20);
    drive(1, 1, 50, 1, 1, 2, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 1);
    idle(1);
    snap(0, 0); idle(1);
    snap(1, 0); idle(1);
    snap(2, 0); idle(2);
  endtask

  task automatic test_out_of_range_and_ignore;
    samp(0, 8);
    snap(3, 1); idle(2);
    snap(0, 0); snap(1, 0);
    idle(2);
  endtask

  task automatic test_reset_abort;
    samp(0, 5);
    snap(0, 0);
    n_cmp++;
    if (snap_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_busy: got %b, expected 1", snap_busy);
    end
    #1 nreset = 1'b0;
    exp_q.delete();
    m_busy = 1'b0;
    for (int c = 0; c < CH; c++) m_empty(c);
    #1;
    n_cmp++;
    if (snap_busy !== 1'b0 || out_valid !== 1'b0 || out_sum !== '0 ||
        out_count !== '0 || out_min !== 16'hFFFF || out_max !== 16'h0000 || out_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_outputs: got busy=%b valid=%b sum=%h cnt=%0d min=%h max=%h ovf=%b, expected 0 0 0 0 ffff 0000 0",
               snap_busy, out_valid, out_sum, out_count, out_min, out_max, out_ovf);
    end
    @(negedge clk);
    nreset = 1'b1;
    idle(3);
    samp(1, 2);
    snap(1, 0); idle(1);
    snap(0, 0); idle(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_interleave_en();
    test_saturation();
    test_cor_coincident();
    test_clear_capture();
    test_out_of_range_and_ignore();
    test_reset_abort();
    idle(4);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL snap_missing: %0d expected snapshots never appeared, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stat_accum.md
# stat_accum

Parametrised multi-channel streaming statistics accumulator, successor to the single-channel sum / sum-of-squares accumulator in the FPGA interface datapath. Keeps per-channel sum, sum of squares, sample count, minimum, maximum and a sticky saturation flag. Statistics are read out through a snapshot handshake with optional clear-on-read. It sits between the ADC sample stream and the host register interface.

## Interface
- `DATA_W`, 16: sample width, unsigned.
- `CH`, 4: channel count, ≥1; `CH_W` = max(1, clog2(CH)).
- `ACC_W`, 64: sum and sum-of-squares width, ≥ 2·`DATA_W`.
- `CNT_W`, 32: sample counter width.

- `clk`: in, 1, sole clock.
- `nreset`: in, 1, asynchronous active-low reset.
- `en`: in, 1, accumulate enable; samples are ignored while low.
- `in_valid`: in, 1, sample strobe.
- `in_ch`: in, `CH_W`, channel of the sample; a value ≥ `CH` drops the sample.
- `in_data`: in, `DATA_W`, sample.
- `clear`: in, 1, synchronous clear of all channels.
- `snap_req`: in, 1, snapshot request pulse.
- `snap_ch`: in, `CH_W`, channel to snapshot.
- `snap_clr`: in, 1, clear that channel on read; sampled with `snap_req`.
- `snap_busy`: out, 1, high while a snapshot is outstanding.
- `out_valid`: out, 1, one-cycle strobe; the `out_*` fields are valid.
- `out_sum`, `out_sumsq`: out, `ACC_W`.
- `out_count`: out, `CNT_W`.
- `out_min`, `out_max`: out, `DATA_W`.
- `out_ovf`: out, 1, sticky saturation flag for the channel.

## Operation
- Stage 1 registers `ch`, `data` and `data*data` (2·`DATA_W`, zero-extended) when `in_valid & en` and `in_ch < CH`. Otherwise the stage-1 valid bit is 0.
- Stage 2 updates the addressed lane:
  - sum += data
  - sumsq += square
  - count += 1
  - min = min(min, data)
  - max = max(max, data)
- Saturation: sum, sumsq and count clamp at all-ones. Any clamp sets the lane `ovf`, which stays set until that lane is cleared.
- Empty-lane values: sum, sumsq, count = 0; min = all-ones; max = 0; ovf = 0.
- Clear priority at a single edge:
  - `clear` > snapshot clear-on-read > stage-2 update.
  - `clear` empties every lane and drops the stage-1 sample in flight.
- Snapshot FSM, states IDLE → CAPTURE → IDLE:
  - In IDLE, `snap_req` latches `snap_ch` and `snap_clr` and moves to CAPTURE.
  - CAPTURE copies the lane values from before the edge into `out_*`, pulses `out_valid` and returns to IDLE.
  - `snap_req` while in CAPTURE is ignored.
  - `snap_ch` ≥ `CH` returns empty-lane values with `out_ovf` = 1.
- Clear-on-read with a coincident stage-2 sample on the same lane: the lane is loaded with that sample's contribution (sum = data, count = 1, min = max = data). No sample is lost or double-counted.
- `clear` coincident with CAPTURE: the snapshot returns pre-clear values.

## Timing
- Reset values: every output 0 except `out_min` = all-ones. All lanes empty, FSM in IDLE, stage-1 valid 0.
- Sample accepted at edge E appears in the lane after edge E+1.
- Snapshot:
  - `snap_req` sampled at edge S.
  - `snap_busy` is high during cycle S..S+1.
  - `out_valid` is high for exactly one cycle after edge S+1.
  - The snapshot includes every sample accepted at edges ≤ S-1.
- `out_*` hold their values until the next `out_valid`.
- Throughput: one sample per cycle. Snapshots never stall input.
- Deasserting `nreset` mid-snapshot aborts it: no `out_valid` is issued and the FSM returns to IDLE.

## Structure
- Package `stat_pkg`:
  - snapshot FSM state enum
  - saturating-add function (parameterised width)
  - empty-lane constants
- Sub-module `stat_lane`: holds one channel's registers. Ports:
  - `upd`, `data`, `square`
  - `clr`, `clr_load` (clear-on-read with coincident sample)
  - outputs: sum, sumsq, count, min, max, ovf
- The top instantiates `CH` lanes in a generate loop and adds stage 1, the snapshot FSM and the output mux.

## Test plan
- Ch2 receives 3, 5, 7, then snapshot ch2 → sum 15, sumsq 83, count 3, min 3, max 7, ovf 0; other channels empty.
- Samples on ch0 and ch1 interleaved every cycle, `en` dropped for 2 cycles mid-stream → counts exclude exactly the masked samples.
- `ACC_W`=32, `DATA_W`=16: 0xFFFF repeated until sumsq clamps → sumsq = 0xFFFFFFFF, ovf = 1 and stays 1 after further samples; `snap_clr` then yields ovf 0.
- Snapshot ch1 with `snap_clr` while a sample of 9 on ch1 is in stage 2 → output excludes 9; the next snapshot shows count 1, sum 9, min = max = 9.
- `clear` asserted in the CAPTURE cycle → snapshot shows pre-clear values; all lanes empty afterwards.
- `nreset` pulsed during `snap_busy` → no `out_valid`; outputs at reset values; a new request succeeds.
